// File: rtl/node_pkg.sv
// Shared types and constants for the node_share_arb block: FSM state encoding,
// default operand width and an index-width helper.
package node_pkg;

    localparam int NODE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/node_share_arb_if.sv
// Requester-side and node-side signals of node_share_arb. The slave modport is
// the arbiter; the master modport is the requesters plus the shared node.
interface node_share_arb_if
    import node_pkg::*;
#(
    parameter int N = 4,
    parameter int W = NODE_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] opa;
    logic [N*W-1:0] opb;
    logic [N-1:0]   ack;
    logic [W-1:0]   res;
    logic           err;
    logic           busy;
    logic           node_st;
    logic           node_rd;
    logic [W-1:0]   node_res;
    logic [W-1:0]   node_in0;
    logic [W-1:0]   node_in1;

    modport master (
        output req, opa, opb, node_rd, node_res,
        input  ack, res, err, busy, node_st, node_in0, node_in1
    );

    modport slave (
        input  req, opa, opb, node_rd, node_res,
        output ack, res, err, busy, node_st, node_in0, node_in1
    );
endinterface

// File: rtl/node_share_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1
// (mod N) wins.
module rr_arbiter
    import node_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0] cand;

    // NOTE: every output gets a default before the search so no path leaves a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_grant_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/node_share_arb.sv
// Shares one multi-cycle node among N requesters, round-robin, one job at a time.
// Define NODE_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with ERR.
module node_share_arb
    import node_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = NODE_W,
    parameter int TIMEOUT = 255
) (
    input logic            clk_i,
    input logic            rst_i,
    node_share_arb_if.slave bus
);
    localparam int IW = idx_width(N);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] last_q, last_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  in0_q, in0_d;
    logic [W-1:0]  in1_q, in1_d;
    logic [W-1:0]  res_q, res_d;
    logic          first_q, first_d;

    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_idx;
    logic          arb_valid;

`ifdef NODE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req_i        (bus.req),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .idx_o        (arb_idx),
        .valid_o      (arb_valid)
    );

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IW'(N - 1);
            gnt_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
`ifdef NODE_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            res_q   <= res_d;
            first_q <= first_d;
`ifdef NODE_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        res_d   = res_q;
        first_d = first_q;
`ifdef NODE_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    idx_d   = arb_idx;
                    gnt_d   = arb_grant;
                    in0_d   = bus.opa[int'(arb_idx)*W +: W];
                    in1_d   = bus.opb[int'(arb_idx)*W +: W];
                    state_d = START;
                end
            end
            START: begin
                first_d = 1'b1;
                state_d = WAIT;
`ifdef NODE_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            WAIT: begin
                // The node still shows the previous job's ready in the first WAIT cycle.
                first_d = 1'b0;
                if (!first_q && bus.node_rd) begin
                    res_d   = bus.node_res;
                    state_d = DONE;
                end
`ifdef NODE_ARB_TIMEOUT_EN
                else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
                cnt_d = cnt_q + CW'(1);
`endif
            end
            DONE: begin
                last_d  = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.node_st  = (state_q == START);
    assign bus.ack      = (state_q == DONE) ? gnt_q : '0;
    assign bus.res      = res_q;
    assign bus.node_in0 = in0_q;
    assign bus.node_in1 = in1_q;
`ifdef NODE_ARB_TIMEOUT_EN
    assign bus.err      = (state_q == DONE) && err_q;
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_node_share_arb.sv
// Scoreboard bench for node_share_arb: a transaction-level model predicts every
// grant, result and completion cycle; a monitor compares whatever the DUT emits.
module tb_node_share_arb;
    import node_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 8;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         err;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    node_share_arb_if #(.N(N), .W(W)) bus ();

    node_share_arb #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   ndq[$];
    int   ack_log[$];
    bit   log_en = 1'b0;

    // Reference model state.
    int m_last  = N - 1;
    int m_free  = 0;
    int m_start = -1;
    int m_ack   = -1;
    int m_svc   = -1;
    bit m_fly   = 1'b0;
    int force_d = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] svc_mask();
        return m_fly ? (N'(1) << m_svc) : '0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ack"},  bus.ack,      '0);
        check({tag, "_err"},  bus.err,      '0);
        check({tag, "_res"},  bus.res,      '0);
        check({tag, "_st"},   bus.node_st,  '0);
        check({tag, "_in0"},  bus.node_in0, '0);
        check({tag, "_in1"},  bus.node_in1, '0);
        check({tag, "_busy"}, bus.busy,     '0);
    endtask

    // Hold the in-service request until its ACK, then wait for the model to go idle.
    task automatic drain(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            bus.req = svc_mask();
            if (!m_fly && sb.size() == 0) break;
        end
        if (k == max_cyc) check("drain_timeout", 64'(sb.size()), 0);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            bus.opa[i*W +: W] = W'($urandom);
            bus.opb[i*W +: W] = W'($urandom);
        end
    endtask

    // Model: one grant per idle window, chosen from the sampled request vector.
    initial begin
        int g, d, c;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                ndq.delete();
                m_fly  = 1'b0;
                m_svc  = -1;
                m_last = N - 1;
                m_free = cyc + 1;
            end else begin
                if (m_fly && cyc > m_ack) begin
                    m_fly = 1'b0;
                    m_svc = -1;
                end
                if (!m_fly && cyc >= m_free && bus.req != '0) begin
                    g = -1;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (g < 0 && bus.req[c]) g = c;
                    end
                    d = (force_d >= 0) ? force_d : int'($urandom_range(1, 6));
                    e.idx = g;
                    e.err = 1'b0;
                    e.res = W'(bus.opa[g*W +: W] + bus.opb[g*W +: W]);
                    e.due = cyc + ((d + 1 > 3) ? d + 1 : 3);
`ifdef NODE_ARB_TIMEOUT_EN
                    if (cyc + TMO + 1 < e.due) begin
                        e.due = cyc + TMO + 1;
                        e.err = 1'b1;
                        e.res = '0;
                    end
`endif
                    sb.push_back(e);
                    ndq.push_back(d);
                    m_fly   = 1'b1;
                    m_svc   = g;
                    m_start = cyc;
                    m_ack   = e.due;
                    m_free  = e.due + 2;
                    m_last  = g;
                end
            end
        end
    end

    // Shared node: drops ready after seeing a start, raises it d cycles later with a+b.
    initial begin
        int cnt;
        bit pend;
        logic [W-1:0] a, b;
        pend = 1'b0;
        cnt  = 0;
        bus.node_rd  = 1'b0;
        bus.node_res = '0;
        forever begin
            @(negedge clk);
            if (bus.node_st === 1'b1) begin
                cnt  = (ndq.size() > 0) ? ndq.pop_front() : 2;
                a    = bus.node_in0;
                b    = bus.node_in1;
                pend = 1'b1;
                bus.node_rd = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    bus.node_rd  = 1'b1;
                    bus.node_res = W'(a + b);
                    pend = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever an ACK appears or is overdue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("busy", bus.busy, m_fly);
            check("node_st", bus.node_st, (m_fly && cyc == m_start));
            if (bus.ack != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", bus.ack, '0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vec",   bus.ack, 64'(1) << e.idx);
                    check("ack_res",   bus.res, e.res);
                    check("ack_err",   bus.err, e.err);
                    check("ack_cycle", 64'(cyc), 64'(e.due));
                    if (log_en) ack_log.push_back(e.idx);
                end
            end else begin
                check("err_idle", bus.err, 1'b0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    check("ack_missing", bus.ack, 64'(1) << e.idx);
                end
            end
        end
    end

    initial begin
        int k;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        bus.req = '0;
        bus.opa = '0;
        bus.opb = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Single request, node answers after 5 cycles; operands changed after grant.
        rst = 1'b0;
        force_d = 5;
        bus.req = 4'b0001;
        bus.opa[0 +: W] = 16'h0003;
        bus.opb[0 +: W] = 16'h0004;
        @(negedge clk);
        bus.opa = '1;
        bus.opb = '1;
        repeat (3) @(negedge clk);
        check("capt_in0", bus.node_in0, 16'h0003);
        check("capt_in1", bus.node_in1, 16'h0004);
        drain(40);
        repeat (2) @(negedge clk);
        check("hold_in0", bus.node_in0, 16'h0003);
        check("hold_in1", bus.node_in1, 16'h0004);
        force_d = -1;

        // All requesters held: round-robin order from requester 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_log.delete();
        log_en = 1'b1;
        bus.req = '1;
        for (int i = 0; i < 60; i++) begin
            rand_ops();
            @(negedge clk);
        end
        drain(40);
        log_en = 1'b0;
        check("rr_count", 64'(ack_log.size() >= 5), 1);
        for (int i = 0; i < 5; i++)
            check("rr_order", (i < ack_log.size()) ? 64'(ack_log[i]) : 64'hdead, 64'(order[i]));

        // Reset in the middle of WAIT, then a late ready while idle.
        force_d = 60;
        bus.req = 4'b0100;
        for (k = 0; k < 50 && !(m_fly && cyc >= m_start + 3); k++) @(negedge clk);
        check("reach_wait", 64'(k < 50), 1);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midwait_rst");
        force_d = -1;
        repeat (70) @(negedge clk);
        check("late_rd_seen", bus.node_rd, 1'b1);
        bus.req = 4'b1100;
        rand_ops();
        drain(40);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            bus.req = N'($urandom) | svc_mask();
            rand_ops();
        end
        rst = 1'b0;
        drain(40);

        // Node that never answers.
        force_d = 1000;
        bus.req = 4'b0010;
`ifdef NODE_ARB_TIMEOUT_EN
        drain(TMO + 20);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.req = svc_mask();
        end
        check("stuck_busy", bus.busy, 1'b1);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        check_zero("stuck_rst");
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/node_share_arb.md
NODE_SHARE_ARB -- requirements
Module: node_share_arb

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one node instance.
REQ-002 Parameter W, default 16: operand and result width.
REQ-003 Parameter TIMEOUT, default 255: watchdog limit in cycles; used only when NODE_ARB_TIMEOUT_EN is defined.
REQ-004 CLK  input  1: single clock; all state changes on the rising edge.
REQ-005 RST  input  1: reset, synchronous and active-high.
REQ-006 REQ  input  N: per-requester request level, held until that requester's ACK.
REQ-007 OPA  input  N*W: packed first operands; requester i occupies bits [i*W +: W].
REQ-008 OPB  input  N*W: packed second operands, same packing as OPA.
REQ-009 ACK  output  N: one-hot, one-cycle completion pulse.
REQ-010 RES  output  W: result, valid only in the ACK cycle.
REQ-011 ERR  output  1: timeout abort flag, pulses together with ACK.
REQ-012 BUSY  output  1: high in every state except IDLE.
REQ-013 NODE_ST  output  1: start pulse to the shared node.
REQ-014 NODE_RD  input  1: ready from the shared node.
REQ-015 NODE_RES  input  W: result from the shared node.
REQ-016 NODE_IN0  output  W: node operand 0, registered.
REQ-017 NODE_IN1  output  W: node operand 1, registered.

Function
REQ-018 Node contract: after sampling NODE_ST high, the node drives NODE_RD low on the next cycle, then raises it with NODE_RES valid at least one cycle later.
REQ-019 FSM states and transitions: IDLE -> START -> WAIT -> DONE -> IDLE.
REQ-020 IDLE: when any REQ bit is high, grant one requester round-robin, starting the search at last_grant+1 modulo N.
REQ-021 On grant, latch the requester index, capture its OPA/OPB slices into NODE_IN0/NODE_IN1, and enter START.
REQ-022 START: NODE_ST is high for exactly one cycle, then the FSM enters WAIT.
REQ-023 WAIT: the first cycle ignores NODE_RD; from the second cycle on, NODE_RD high registers NODE_RES into RES and enters DONE.
REQ-024 DONE: ACK[idx] is high for one cycle, last_grant becomes idx, and the FSM returns to IDLE.
REQ-025 Latency: REQ seen in IDLE at cycle t gives NODE_ST at t+1; NODE_RD first sampled at t+3; NODE_RD high sampled at w gives ACK at w+1.
REQ-026 Requests arriving while BUSY wait; operands are sampled only at grant, and later operand changes are ignored.
REQ-027 A requester that drops REQ before grant is skipped; there is no pending memory.
REQ-028 Simultaneous requests: round-robin guarantees each active requester is served within N grants.
REQ-029 NODE_ST, ACK and ERR are never high outside START or DONE.

Reset
REQ-030 RST high forces, on the next edge and from any state including mid-WAIT: IDLE, ACK=0, ERR=0, RES=0, NODE_ST=0, NODE_IN0=0, NODE_IN1=0, BUSY=0.
REQ-031 Reset sets last_grant=N-1, so requester 0 has first priority.
REQ-032 An in-flight node operation is abandoned on reset; a NODE_RD arriving afterwards is ignored while in IDLE.

Configuration
REQ-033 Macro NODE_ARB_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
REQ-034 With the macro defined, reaching TIMEOUT without NODE_RD enters DONE with RES=0, ERR=1 and ACK[idx]=1.
REQ-035 Without the macro: no counter exists, WAIT is unbounded, and ERR is tied to 0.

Structure
REQ-036 Shared package node_pkg holds the FSM state enum (IDLE, START, WAIT, DONE) and the default width constant W=16.
REQ-037 Sub-module rr_arbiter (inputs REQ and last_grant; outputs one-hot grant, index and valid) is purely combinational and instantiated once.

Verification
REQ-038 Single request: REQ=0001, OPA0=0x0003, OPB0=0x0004, node returns 0x0007 after 5 cycles -> NODE_ST one pulse, ACK=0001 with RES=0x0007, BUSY low afterwards.
REQ-039 All four REQ held continuously -> grant order 0,1,2,3,0; each ACK one-hot; no NODE_ST overlap.
REQ-040 Reset asserted mid-WAIT with REQ=0100 -> next cycle IDLE with all outputs 0; a late NODE_RD produces no ACK; the next grant goes to requester 2 under priority from 0.
REQ-041 Operands changed to 0xFFFF after grant -> NODE_IN0/NODE_IN1 keep the captured values until the next grant.
REQ-042 With NODE_ARB_TIMEOUT_EN defined and TIMEOUT=8, node never raises RD -> ACK and ERR=1 after 8 WAIT cycles, RES=0; without the macro, BUSY stays high indefinitely.
